// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - framed UART image loader that fills program BSRAM, then releases the CPU
module uart_boot_loader #(
    parameter int         DATA_W      = 16,
    parameter int         ADDR_W      = 11,
    parameter int         MAX_WORDS   = 2048,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 27_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              mem_ce,
    output logic              mem_wre,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              boot_mode,
    output logic              boot_done,
    output logic              boot_err,
    output logic              boot_timeout,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int                BPW       = DATA_W / 8;
    localparam int                BIDX_W    = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BPW - 1);
    localparam bit                TO_EN     = (TIMEOUT_CYC > 0);
    localparam logic [31:0]       TO_LAST   = TO_EN ? 32'(TIMEOUT_CYC - 1) : 32'd0;
    localparam logic [16:0]       MAX_LEN   = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_ERR, S_DONE
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [31:0]         to_cnt;
    logic                to_armed;
    logic [7:0]          csum;
    logic [7:0]          len_lo;
    logic [15:0]         len;
    logic [15:0]         rx_words;
    logic [BIDX_W-1:0]   byte_idx;
    logic [DATA_W-1:0]   shift;
    logic                wre_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   din_q;
    logic [ADDR_W:0]     words_q;
    logic                err_q;
    logic                timeout_q;

    logic                sync_hit;
    logic                timeout_hit;
    logic [15:0]         len_full;
    logic                byte_last;
    logic [DATA_W-1:0]   shift_next;

    // The first byte of a word ends up in bits [7:0] after BPW right shifts
    assign shift_next  = (shift >> 8) | (DATA_W'(rx_data) << (DATA_W - 8));
    assign len_full    = {rx_data, len_lo};
    assign byte_last   = (byte_idx == LAST_BYTE);
    assign sync_hit    = (state == S_IDLE) && rx_valid && (rx_data == SYNC_BYTE);
    // A SYNC arriving on the last timeout cycle wins over the fallback
    assign timeout_hit = TO_EN && (state == S_IDLE) && to_armed && (to_cnt == TO_LAST) && !sync_hit;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (sync_hit)         next_state = S_LEN_LO;
                else if (timeout_hit) next_state = S_DONE;
            end
            S_LEN_LO: if (rx_valid) next_state = S_LEN_HI;
            S_LEN_HI: begin
                if (rx_valid) begin
                    if ({1'b0, len_full} > MAX_LEN) next_state = S_ERR;
                    else if (len_full == 16'd0)     next_state = S_CSUM;
                    else                            next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (rx_valid && byte_last && (16'(rx_words + 16'd1) == len)) next_state = S_CSUM;
            end
            S_CSUM: if (rx_valid) next_state = (rx_data == csum) ? S_DONE : S_ERR;
            S_ERR:  next_state = S_IDLE;
            S_DONE: next_state = S_DONE;
            default: next_state = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        mem_ce    = 1'b1;
        boot_mode = (state != S_DONE);
        boot_done = (state == S_DONE);
    end

    // Datapath: timeout, checksum, word assembly and the pipelined write
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt    <= '0;
            to_armed  <= 1'b1;
            csum      <= '0;
            len_lo    <= '0;
            len       <= '0;
            rx_words  <= '0;
            byte_idx  <= '0;
            shift     <= '0;
            wre_q     <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            words_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            wre_q <= 1'b0;
            if (wre_q) begin
                addr_q  <= addr_q + 1'b1;
                words_q <= words_q + 1'b1;
            end
            if (TO_EN && state == S_IDLE && to_armed) to_cnt <= to_cnt + 32'd1;
            if (next_state == S_ERR) err_q <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (sync_hit) begin
                        to_armed <= 1'b0;
                        err_q    <= 1'b0;
                        words_q  <= '0;
                        csum     <= '0;
                        byte_idx <= '0;
                        addr_q   <= '0;
                        rx_words <= '0;
                    end else if (timeout_hit) begin
                        timeout_q <= 1'b1;
                    end
                end
                S_LEN_LO: begin
                    if (rx_valid) begin
                        len_lo <= rx_data;
                        csum   <= csum + rx_data;
                    end
                end
                S_LEN_HI: begin
                    if (rx_valid) begin
                        len  <= len_full;
                        csum <= csum + rx_data;
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        csum  <= csum + rx_data;
                        shift <= shift_next;
                        if (byte_last) begin
                            byte_idx <= '0;
                            wre_q    <= 1'b1;
                            din_q    <= shift_next;
                            rx_words <= rx_words + 16'd1;
                        end else begin
                            byte_idx <= byte_idx + BIDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_wre      = wre_q;
    assign mem_addr     = addr_q;
    assign mem_din      = din_q;
    assign words_loaded = words_q;
    assign boot_err     = err_q;
    assign boot_timeout = timeout_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - scoreboard bench for uart_boot_loader with a frame-level reference model
module tb_uart_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [7:0]  rx_data_a = 8'h00, rx_data_b = 8'h00;
    logic        rx_valid_a = 1'b0, rx_valid_b = 1'b0;

    logic        ce_a, wre_a, mode_a, done_a, err_a, tout_a;
    logic [10:0] addr_a;
    logic [15:0] din_a;
    logic [11:0] wl_a;

    logic        ce_b, wre_b, mode_b, done_b, err_b, tout_b;
    logic [3:0]  addr_b;
    logic [31:0] din_b;
    logic [4:0]  wl_b;

    uart_boot_loader #(.DATA_W(16), .ADDR_W(11), .MAX_WORDS(2048), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(100)) u_a (
        .clk(clk), .rst(rst), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .mem_ce(ce_a), .mem_wre(wre_a), .mem_addr(addr_a), .mem_din(din_a),
        .boot_mode(mode_a), .boot_done(done_a), .boot_err(err_a), .boot_timeout(tout_a),
        .words_loaded(wl_a)
    );

    uart_boot_loader #(.DATA_W(32), .ADDR_W(4), .MAX_WORDS(16), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(0)) u_b (
        .clk(clk), .rst(rst), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .mem_ce(ce_b), .mem_wre(wre_b), .mem_addr(addr_b), .mem_din(din_b),
        .boot_mode(mode_b), .boot_done(done_b), .boot_err(err_b), .boot_timeout(tout_b),
        .words_loaded(wl_b)
    );

    typedef struct {
        int unsigned addr;
        logic [63:0] data;
    } wr_t;

    int         n_vec = 0;
    int         n_bad = 0;
    wr_t        q_a[$];
    wr_t        q_b[$];
    logic [7:0] frame[$];
    bit         exp_err, exp_done;
    int         exp_words;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitors: every mem_wre pulse must match the head of the expected queue
    always @(negedge clk) begin
        if (wre_a === 1'b1) begin
            if (q_a.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL wr_a_unexpected: got addr %0h data %0h expected no write", addr_a, din_a);
            end else begin
                wr_t e;
                e = q_a.pop_front();
                check("wr_a_addr", 64'(addr_a), 64'(e.addr));
                check("wr_a_data", 64'(din_a), e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (wre_b === 1'b1) begin
            if (q_b.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL wr_b_unexpected: got addr %0h data %0h expected no write", addr_b, din_b);
            end else begin
                wr_t e;
                e = q_b.pop_front();
                check("wr_b_addr", 64'(addr_b), 64'(e.addr));
                check("wr_b_data", 64'(din_b), e.data);
            end
        end
    end

    // Reference model: parse the whole frame and predict writes and final status
    task automatic model(input int sel);
        int         bpw, maxw, len;
        logic [7:0] sum;
        logic [63:0] w;
        wr_t        e;
        bpw  = sel ? 4 : 2;
        maxw = sel ? 16 : 2048;
        len  = int'(frame[1]) + 256 * int'(frame[2]);
        if (len > maxw) begin
            exp_err = 1'b1; exp_done = 1'b0; exp_words = 0;
            return;
        end
        sum = 8'h00;
        for (int i = 1; i < frame.size() - 1; i++) sum = sum + frame[i];
        for (int wi = 0; wi < len; wi++) begin
            w = 64'd0;
            for (int k = 0; k < bpw; k++) w = w | (64'(frame[3 + wi * bpw + k]) << (8 * k));
            e.addr = wi;
            e.data = w;
            if (sel) q_b.push_back(e);
            else     q_a.push_back(e);
        end
        exp_done  = (sum == frame[frame.size() - 1]);
        exp_err   = !exp_done;
        exp_words = len;
    endtask

    task automatic build_frame(input int len, input int bpw, input bit good);
        logic [7:0] sum, b;
        frame = {};
        frame.push_back(8'hA5);
        frame.push_back(8'(len));
        frame.push_back(8'(len >> 8));
        sum = 8'(len) + 8'(len >> 8);
        for (int i = 0; i < len * bpw; i++) begin
            b = ($urandom_range(0, 5) == 0) ? 8'hA5 : 8'($urandom);
            frame.push_back(b);
            sum = sum + b;
        end
        if (!good) sum = sum + 8'($urandom_range(1, 255));
        frame.push_back(sum);
    endtask

    task automatic send_byte(input int sel, input logic [7:0] b);
        if (sel) begin rx_data_b = b; rx_valid_b = 1'b1; end
        else     begin rx_data_a = b; rx_valid_a = 1'b1; end
        @(posedge clk);
        #1;
        rx_valid_a = 1'b0;
        rx_valid_b = 1'b0;
    endtask

    task automatic send_frame(input int sel, input int gapmax);
        int g;
        foreach (frame[i]) begin
            g = $urandom_range(0, gapmax);
            if (g > 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
            send_byte(sel, frame[i]);
        end
    endtask

    task automatic reset_check();
        rst = 1'b1;
        rx_valid_a = 1'b0;
        rx_valid_b = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mode", 64'(mode_a), 64'd1);
        check("rst_ce", 64'(ce_a), 64'd1);
        check("rst_wre", 64'(wre_a), 64'd0);
        check("rst_addr", 64'(addr_a), 64'd0);
        check("rst_din", 64'(din_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_err", 64'(err_a), 64'd0);
        check("rst_tout", 64'(tout_a), 64'd0);
        check("rst_words", 64'(wl_a), 64'd0);
        check("rst_b_mode", 64'(mode_b), 64'd1);
        check("rst_b_words", 64'(wl_b), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic status(input int sel);
        repeat (5) @(posedge clk);
        @(negedge clk);
        if (sel) begin
            check("b_done", 64'(done_b), 64'(exp_done));
            check("b_err", 64'(err_b), 64'(exp_err));
            check("b_mode", 64'(mode_b), 64'(!exp_done));
            check("b_words", 64'(wl_b), 64'(exp_words));
            check("b_tout", 64'(tout_b), 64'd0);
            check("b_ce", 64'(ce_b), 64'd1);
            check("b_q_left", 64'(q_b.size()), 64'd0);
        end else begin
            check("a_done", 64'(done_a), 64'(exp_done));
            check("a_err", 64'(err_a), 64'(exp_err));
            check("a_mode", 64'(mode_a), 64'(!exp_done));
            check("a_words", 64'(wl_a), 64'(exp_words));
            check("a_tout", 64'(tout_a), 64'd0);
            check("a_q_left", 64'(q_a.size()), 64'd0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test expected finish within time limit");
        $fatal(1);
    end

    initial begin
        wr_t e;
        int  sel, len;

        // Directed 3-word frame
        reset_check();
        frame = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h68};
        model(0);
        check("model_first_word", q_a[0].data, 64'h2211);
        send_frame(0, 2);
        status(0);

        // Bad checksum, then recovery with a good frame
        reset_check();
        frame = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00};
        model(0);
        send_frame(0, 2);
        status(0);
        build_frame(4, 2, 1'b1);
        model(0);
        send_frame(0, 3);
        status(0);

        // Oversized length
        reset_check();
        frame = '{8'hA5, 8'h01, 8'h08};
        model(0);
        send_frame(0, 1);
        status(0);

        // Zero-length frame
        reset_check();
        frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
        model(0);
        send_frame(0, 1);
        status(0);

        // Timeout fallback after exactly 100 cycles
        reset_check();
        repeat (99) @(posedge clk);
        @(negedge clk);
        check("to_done_early", 64'(done_a), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("to_done", 64'(done_a), 64'd1);
        check("to_flag", 64'(tout_a), 64'd1);
        check("to_mode", 64'(mode_a), 64'd0);

        // SYNC at cycle 50 disables the timeout
        reset_check();
        repeat (49) @(posedge clk);
        #1;
        send_byte(0, 8'hA5);
        repeat (200) @(posedge clk);
        @(negedge clk);
        check("to_off_done", 64'(done_a), 64'd0);
        check("to_off_flag", 64'(tout_a), 64'd0);
        check("to_off_mode", 64'(mode_a), 64'd1);

        // 32-bit words, back-to-back bytes
        reset_check();
        build_frame(2, 4, 1'b1);
        model(1);
        send_frame(1, 0);
        status(1);

        // 32-bit instance oversized length
        reset_check();
        frame = '{8'hA5, 8'h11, 8'h00};
        model(1);
        send_frame(1, 0);
        status(1);

        // Reset in the middle of the second word
        reset_check();
        frame = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33};
        e.addr = 0;
        e.data = 64'h2211;
        q_a.push_back(e);
        send_frame(0, 0);
        @(negedge clk);
        check("mid_q_left", 64'(q_a.size()), 64'd0);
        reset_check();
        build_frame(3, 2, 1'b1);
        model(0);
        send_frame(0, 1);
        status(0);

        // Randomized frames on both instances
        for (int it = 0; it < 12; it++) begin
            sel = it % 2;
            reset_check();
            len = $urandom_range(0, sel ? 16 : 8);
            build_frame(len, sel ? 4 : 2, $urandom_range(0, 4) != 0);
            model(sel);
            send_frame(sel, $urandom_range(0, 3));
            status(sel);
        end

        // Largest image, back-to-back
        reset_check();
        build_frame(2048, 2, 1'b1);
        model(0);
        send_frame(0, 0);
        status(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
